// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, aluOp and control-word definitions for the decode stage
package mips_pkg;

  typedef enum logic [5:0] {
    R_TYPE = 6'b000000,
    LW     = 6'b100011,
    SW     = 6'b101011,
    BEQ    = 6'b000100,
    ADDI   = 6'b001000
  } opcode_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dest;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Unknown opcodes fall through to an all-zero control word.
  function automatic ctrl_t decode_opcode(input logic [5:0] opcode);
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (opcode)
      R_TYPE: begin
        c.alu_op    = ALUOP_FUNCT;
        c.reg_dest  = 1'b1;
        c.reg_write = 1'b1;
      end
      LW: begin
        c.alu_op     = ALUOP_ADD;
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      SW: begin
        c.alu_op    = ALUOP_ADD;
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      BEQ: begin
        c.alu_op = ALUOP_SUB;
        c.branch = 1'b1;
      end
      ADDI: begin
        c.alu_op    = ALUOP_ADD;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      default: c = CTRL_BUBBLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - IF/ID, write-back and ID/EX signal bundle around the decode stage
interface decode_stage_if;

  logic [31:0] instruction_if_id;
  logic [31:0] supposed_next_address_if_id;
  logic        valid_if_id;
  logic        flush;

  logic        wb_reg_write;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_write_data;

  logic [31:0] read_data_1_id_ex;
  logic [31:0] read_data_2_id_ex;
  logic [31:0] extended_branch_offset_id_ex;
  logic [31:0] supposed_next_address_id_ex;
  logic [4:0]  next_instruction_20_16_id_ex;
  logic [4:0]  next_instruction_15_11_id_ex;
  logic [1:0]  ctrl_aluOp_id_ex;
  logic        ctrl_aluSrc_id_ex;
  logic        ctrl_regDest_id_ex;
  logic        ctrl_branch_id_ex;
  logic        ctrl_memRead_id_ex;
  logic        ctrl_memWrite_id_ex;
  logic        ctrl_memToReg_id_ex;
  logic        ctrl_regWrite_id_ex;

  logic        stall_if;

  modport master (
    output instruction_if_id, supposed_next_address_if_id, valid_if_id, flush,
    output wb_reg_write, wb_write_register, wb_write_data,
    input  read_data_1_id_ex, read_data_2_id_ex,
    input  extended_branch_offset_id_ex, supposed_next_address_id_ex,
    input  next_instruction_20_16_id_ex, next_instruction_15_11_id_ex,
    input  ctrl_aluOp_id_ex, ctrl_aluSrc_id_ex, ctrl_regDest_id_ex, ctrl_branch_id_ex,
    input  ctrl_memRead_id_ex, ctrl_memWrite_id_ex, ctrl_memToReg_id_ex, ctrl_regWrite_id_ex,
    input  stall_if
  );

  modport slave (
    input  instruction_if_id, supposed_next_address_if_id, valid_if_id, flush,
    input  wb_reg_write, wb_write_register, wb_write_data,
    output read_data_1_id_ex, read_data_2_id_ex,
    output extended_branch_offset_id_ex, supposed_next_address_id_ex,
    output next_instruction_20_16_id_ex, next_instruction_15_11_id_ex,
    output ctrl_aluOp_id_ex, ctrl_aluSrc_id_ex, ctrl_regDest_id_ex, ctrl_branch_id_ex,
    output ctrl_memRead_id_ex, ctrl_memWrite_id_ex, ctrl_memToReg_id_ex, ctrl_regWrite_id_ex,
    output stall_if
  );

endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two async read ports with write-back bypass
module register_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  read_register_1,
  input  logic [4:0]  read_register_2,
  output logic [31:0] read_data_1,
  output logic [31:0] read_data_2,
  input  logic        reg_write,
  input  logic [4:0]  write_register,
  input  logic [31:0] write_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (reg_write && (write_register != 5'd0)) begin
      regs[write_register] <= write_data;
    end
  end

  // Bypass lets the instruction in ID see a value written back on the same edge.
  function automatic logic [31:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0)
      return 32'd0;
    else if (reset && reg_write && (write_register == addr))
      return write_data;
    else
      return regs[addr];
  endfunction

  always_comb begin
    read_data_1 = read_port(read_register_1);
    read_data_2 = read_port(read_register_2);
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: control decode, operand read, load-use stall, ID/EX register
module decode_stage
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] ext_offset;
  ctrl_t       ctrl;
  logic        load_use;
  logic        stall;
  logic        insert_bubble;

  always_comb begin
    opcode     = bus.instruction_if_id[31:26];
    rs         = bus.instruction_if_id[25:21];
    rt         = bus.instruction_if_id[20:16];
    rd         = bus.instruction_if_id[15:11];
    ext_offset = {{16{bus.instruction_if_id[15]}}, bus.instruction_if_id[15:0]};
    ctrl       = decode_opcode(opcode);
  end

  register_file u_register_file (
    .clk             (clk),
    .reset           (reset),
    .read_register_1 (rs),
    .read_register_2 (rt),
    .read_data_1     (rd1),
    .read_data_2     (rd2),
    .reg_write       (bus.wb_reg_write),
    .write_register  (bus.wb_write_register),
    .write_data      (bus.wb_write_data)
  );

  // The bubble loaded during a stall clears memRead, so the stall self-terminates after one cycle.
  always_comb begin
    load_use = bus.ctrl_memRead_id_ex
            && (bus.next_instruction_20_16_id_ex != 5'd0)
            && ((bus.next_instruction_20_16_id_ex == rs) || (bus.next_instruction_20_16_id_ex == rt));
    stall         = load_use && !bus.flush;
    insert_bubble = bus.flush || !bus.valid_if_id || stall;
  end

  assign bus.stall_if = stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || insert_bubble) begin
      bus.read_data_1_id_ex            <= '0;
      bus.read_data_2_id_ex            <= '0;
      bus.extended_branch_offset_id_ex <= '0;
      bus.supposed_next_address_id_ex  <= '0;
      bus.next_instruction_20_16_id_ex <= '0;
      bus.next_instruction_15_11_id_ex <= '0;
      bus.ctrl_aluOp_id_ex             <= '0;
      bus.ctrl_aluSrc_id_ex            <= 1'b0;
      bus.ctrl_regDest_id_ex           <= 1'b0;
      bus.ctrl_branch_id_ex            <= 1'b0;
      bus.ctrl_memRead_id_ex           <= 1'b0;
      bus.ctrl_memWrite_id_ex          <= 1'b0;
      bus.ctrl_memToReg_id_ex          <= 1'b0;
      bus.ctrl_regWrite_id_ex          <= 1'b0;
    end else begin
      bus.read_data_1_id_ex            <= rd1;
      bus.read_data_2_id_ex            <= rd2;
      bus.extended_branch_offset_id_ex <= ext_offset;
      bus.supposed_next_address_id_ex  <= bus.supposed_next_address_if_id;
      bus.next_instruction_20_16_id_ex <= rt;
      bus.next_instruction_15_11_id_ex <= rd;
      bus.ctrl_aluOp_id_ex             <= ctrl.alu_op;
      bus.ctrl_aluSrc_id_ex            <= ctrl.alu_src;
      bus.ctrl_regDest_id_ex           <= ctrl.reg_dest;
      bus.ctrl_branch_id_ex            <= ctrl.branch;
      bus.ctrl_memRead_id_ex           <= ctrl.mem_read;
      bus.ctrl_memWrite_id_ex          <= ctrl.mem_write;
      bus.ctrl_memToReg_id_ex          <= ctrl.mem_to_reg;
      bus.ctrl_regWrite_id_ex          <= ctrl.reg_write;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic [31:0] pc;
    logic [4:0]  r20;
    logic [4:0]  r15;
    logic [8:0]  ctrl;  // {aluOp, aluSrc, regDest, branch, memRead, memWrite, memToReg, regWrite}
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    out_t        exp;
  } vec_t;

  localparam logic [8:0] C_R    = 9'b10_0_1_0_0_0_0_1;
  localparam logic [8:0] C_LW   = 9'b00_1_0_0_1_0_1_1;
  localparam logic [8:0] C_SW   = 9'b00_1_0_0_0_1_0_0;
  localparam logic [8:0] C_BEQ  = 9'b01_0_0_1_0_0_0_0;
  localparam logic [8:0] C_ADDI = 9'b00_1_0_0_0_0_0_1;
  localparam logic [8:0] C_NONE = 9'b00_0_0_0_0_0_0_0;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  out_t sb[$];
  vec_t tbl[8];

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_rec(input string tag, input out_t e);
    logic [8:0] c;
    c = {bus.ctrl_aluOp_id_ex, bus.ctrl_aluSrc_id_ex, bus.ctrl_regDest_id_ex, bus.ctrl_branch_id_ex,
         bus.ctrl_memRead_id_ex, bus.ctrl_memWrite_id_ex, bus.ctrl_memToReg_id_ex, bus.ctrl_regWrite_id_ex};
    chk({tag, ".rd1"},  bus.read_data_1_id_ex, e.rd1);
    chk({tag, ".rd2"},  bus.read_data_2_id_ex, e.rd2);
    chk({tag, ".ext"},  bus.extended_branch_offset_id_ex, e.ext);
    chk({tag, ".pc"},   bus.supposed_next_address_id_ex, e.pc);
    chk({tag, ".r20"},  32'(bus.next_instruction_20_16_id_ex), 32'(e.r20));
    chk({tag, ".r15"},  32'(bus.next_instruction_15_11_id_ex), 32'(e.r15));
    chk({tag, ".ctrl"}, 32'(c), 32'(e.ctrl));
  endtask

  // Drives one decode cycle: expectation pushed at drive time, popped after the ID/EX edge.
  task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic valid, input logic fl,
                       input logic wb_en, input logic [4:0] wb_r, input logic [31:0] wb_d,
                       input logic exp_stall, input out_t e);
    out_t got;
    bus.instruction_if_id           = instr;
    bus.supposed_next_address_if_id = pc;
    bus.valid_if_id                 = valid;
    bus.flush                       = fl;
    bus.wb_reg_write                = wb_en;
    bus.wb_write_register           = wb_r;
    bus.wb_write_data               = wb_d;
    #1;
    chk({tag, ".stall"}, 32'(bus.stall_if), 32'(exp_stall));
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.wb_reg_write = 1'b0;
    bus.flush        = 1'b0;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s.scoreboard actual=empty required=entry", tag);
    end else begin
      got = sb.pop_front();
      check_rec(tag, got);
    end
  endtask

  out_t zero_rec;
  out_t add_rec;
  out_t lw_rec;

  initial begin
    checks   = 0;
    failures = 0;
    zero_rec = '0;
    add_rec  = '{rd1: 32'd5, rd2: 32'd7, ext: 32'h0000_1820, pc: 32'h0000_0204, r20: 5'd2, r15: 5'd3, ctrl: C_R};
    lw_rec   = '{rd1: 32'd5, rd2: 32'd7, ext: 32'hFFFF_FFFC, pc: 32'h0000_0200, r20: 5'd2, r15: 5'd31, ctrl: C_LW};

    tbl[0] = '{"add",   32'h0022_1820, 32'h104, 1'b1, 1'b0,
               '{32'd5, 32'd7, 32'h0000_1820, 32'h104, 5'd2, 5'd3, C_R}};
    tbl[1] = '{"lw",    32'h8C22_FFFC, 32'h108, 1'b1, 1'b0,
               '{32'd5, 32'd7, 32'hFFFF_FFFC, 32'h108, 5'd2, 5'd31, C_LW}};
    tbl[2] = '{"sw",    32'hAC23_0004, 32'h10C, 1'b1, 1'b0,
               '{32'd5, 32'd0, 32'h0000_0004, 32'h10C, 5'd3, 5'd0, C_SW}};
    tbl[3] = '{"beq",   32'h1022_0003, 32'h110, 1'b1, 1'b0,
               '{32'd5, 32'd7, 32'h0000_0003, 32'h110, 5'd2, 5'd0, C_BEQ}};
    tbl[4] = '{"addi",  32'h2022_FFFF, 32'h114, 1'b1, 1'b0,
               '{32'd5, 32'd7, 32'hFFFF_FFFF, 32'h114, 5'd2, 5'd31, C_ADDI}};
    tbl[5] = '{"badop", 32'hFC22_1820, 32'h118, 1'b1, 1'b0,
               '{32'd5, 32'd7, 32'h0000_1820, 32'h118, 5'd2, 5'd3, C_NONE}};
    tbl[6] = '{"novld", 32'h0022_1820, 32'h11C, 1'b0, 1'b0, '0};
    tbl[7] = '{"flush", 32'h0022_1820, 32'h120, 1'b1, 1'b1, '0};

    reset = 1'b0;
    bus.instruction_if_id           = '0;
    bus.supposed_next_address_if_id = '0;
    bus.valid_if_id                 = 1'b0;
    bus.flush                       = 1'b0;
    bus.wb_reg_write                = 1'b0;
    bus.wb_write_register           = '0;
    bus.wb_write_data               = '0;
    @(negedge clk);
    check_rec("reset", zero_rec);
    chk("reset.stall", 32'(bus.stall_if), 32'd0);
    reset = 1'b1;

    issue("wb1", 32'h0022_1820, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5, 1'b0, zero_rec);
    issue("wb2", 32'h0022_1820, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7, 1'b0, zero_rec);

    for (int i = 0; i < 8; i++)
      issue(tbl[i].name, tbl[i].instr, tbl[i].pc, tbl[i].valid, tbl[i].flush,
            1'b0, 5'd0, 32'd0, 1'b0, tbl[i].exp);

    // Load-use: one stall cycle with a bubble, then the add issues.
    issue("lu.lw",     32'h8C22_FFFC, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, lw_rec);
    issue("lu.bubble", 32'h0022_1820, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, zero_rec);
    issue("lu.add",    32'h0022_1820, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, add_rec);

    // Flush wins over a concurrent load-use hazard.
    issue("fl.lw",     32'h8C22_FFFC, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, lw_rec);
    issue("fl.bubble", 32'h0022_1820, 32'h204, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, zero_rec);
    issue("fl.add",    32'h0022_1820, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, add_rec);

    // Write-back bypass, and $0 stays zero.
    issue("byp.r5", 32'h00A0_0020, 32'h300, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0,
          '{32'hDEAD_BEEF, 32'd0, 32'h20, 32'h300, 5'd0, 5'd0, C_R});
    issue("byp.r0", 32'h0000_0020, 32'h304, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0,
          '{32'd0, 32'd0, 32'h20, 32'h304, 5'd0, 5'd0, C_R});
    issue("byp.held", 32'h00A5_0020, 32'h308, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0,
          '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h20, 32'h308, 5'd5, 5'd0, C_R});

    // Reset pulse in the middle of a stall, with a write-back that must be ignored.
    issue("rs.lw", 32'h8C22_FFFC, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, lw_rec);
    bus.instruction_if_id = 32'h0022_1820;
    #1;
    chk("rs.stall_pre", 32'(bus.stall_if), 32'd1);
    bus.wb_reg_write      = 1'b1;
    bus.wb_write_register = 5'd7;
    bus.wb_write_data     = 32'h0000_0077;
    reset = 1'b0;
    #1;
    check_rec("rs.async", zero_rec);
    chk("rs.stall_post", 32'(bus.stall_if), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.wb_reg_write = 1'b0;
    reset = 1'b1;

    for (int k = 0; k < 16; k++) begin
      logic [4:0] ra;
      logic [4:0] rb;
      ra = 5'(2 * k);
      rb = 5'(2 * k + 1);
      issue($sformatf("rs.reg%0d", 2 * k), {6'd0, ra, rb, 5'd0, 5'd0, 6'h20}, 32'h400, 1'b1, 1'b0,
            1'b0, 5'd0, 32'd0, 1'b0, '{32'd0, 32'd0, 32'h20, 32'h400, rb, 5'd0, C_R});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock.
REQ-002 SHALL have reset, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have instruction_if_id, input, 32, fetched instruction from IF/ID.
REQ-004 SHALL have supposed_next_address_if_id, input, 32, PC+4 from IF/ID.
REQ-005 SHALL have valid_if_id, input, 1, IF/ID holds a real instruction.
REQ-006 SHALL have flush, input, 1, squash the current decode (taken branch).
REQ-007 SHALL have wb_reg_write, wb_write_register, wb_write_data, inputs, 1/5/32, write-back port.
REQ-008 SHALL have read_data_1_id_ex and read_data_2_id_ex, outputs, 32 each, rs and rt operands.
REQ-009 SHALL have extended_branch_offset_id_ex and supposed_next_address_id_ex, outputs, 32 each.
REQ-010 SHALL have next_instruction_20_16_id_ex and next_instruction_15_11_id_ex, outputs, 5 each.
REQ-011 SHALL have ctrl_aluOp_id_ex (2) and ctrl_aluSrc_id_ex, ctrl_regDest_id_ex, ctrl_branch_id_ex, ctrl_memRead_id_ex, ctrl_memWrite_id_ex, ctrl_memToReg_id_ex, ctrl_regWrite_id_ex (1 each), as outputs.
REQ-012 SHALL have stall_if, output, 1, combinational, hold PC and IF/ID.

Function
REQ-013 SHALL register every *_id_ex output on the rising clk edge, giving 1-cycle decode latency.
REQ-014 SHALL decode opcode [31:26] as follows: 000000 R-type gives aluOp=10, regDest=1, regWrite=1.
REQ-015 SHALL decode 100011 lw as aluOp=00, aluSrc=1, memRead=1, memToReg=1, regWrite=1.
REQ-016 SHALL decode 101011 sw as aluOp=00, aluSrc=1, memWrite=1.
REQ-017 SHALL decode 000100 beq as aluOp=01, branch=1.
REQ-018 SHALL decode 001000 addi as aluOp=00, aluSrc=1, regWrite=1.
REQ-019 SHALL treat any other opcode as a bubble (all ctrl 0).
REQ-020 SHALL form extended_branch_offset as instruction[15:0] sign-extended to 32 bits, with funct preserved in [5:0].
REQ-021 SHALL contain a 32x32 register file with 2 async read ports (rs=[25:21], rt=[20:16]) and 1 write port written on the clk rise when wb_reg_write=1.
REQ-022 SHALL hard-wire register 0 to read 0 and ignore writes to it.
REQ-023 SHALL bypass same-cycle write-back to a read: if wb_reg_write, wb_write_register!=0 and it equals rs/rt, that read returns wb_write_data.
REQ-024 SHALL detect load-use: if ctrl_memRead_id_ex=1, next_instruction_20_16_id_ex!=0 and it equals rs or rt of the current instruction, then stall_if=1.
REQ-025 SHALL load a bubble into ID/EX while stall_if=1 (all ctrl 0, data fields don't-care but deterministic 0).
REQ-026 SHALL hold a stall for exactly 1 cycle per hazard, after which the same instruction decodes normally.
REQ-027 SHALL load a bubble on the next edge when flush=1 or valid_if_id=0, and SHALL give flush priority over stall (stall_if=0 when flush=1).
REQ-028 SHALL copy supposed_next_address_if_id unchanged into supposed_next_address_id_ex.

Reset
REQ-029 SHALL, while reset=0, immediately clear all *_id_ex outputs and all 32 registers to 0, so stall_if=0.
REQ-030 SHALL ignore write-back on an edge where reset is low, and a mid-operation reset SHALL discard any pending stall.

Structure
REQ-031 SHALL place the opcode constants (R_TYPE, LW, SW, BEQ, ADDI) and the aluOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10) in shared package mips_pkg.
REQ-032 SHALL implement the register file as sub-module register_file; control decode and hazard logic SHALL stay in decode_stage.

Verification
REQ-033 SHALL cover R-type add: wb writes $1=5 then $2=7; decode 0x00221820 -> rd1=5, rd2=7, aluOp=10, regDest=1, regWrite=1, ext[5:0]=100000, _15_11=3.
REQ-034 SHALL cover lw 0x8C22FFFC -> ext=0xFFFFFFFC, aluSrc=1, memRead=1, memToReg=1, _20_16=2.
REQ-035 SHALL cover load-use: lw $2 followed by add using $2 -> stall_if=1 for 1 cycle, 1 bubble, then add issued.
REQ-036 SHALL cover bypass: wb writes $5=0xDEADBEEF in the same cycle an instruction reads $5 -> rd1=0xDEADBEEF; a write to $0=0x1234 -> reads 0.
REQ-037 SHALL cover flush=1 with a concurrent load-use hazard -> stall_if=0 and a bubble next cycle.
REQ-038 SHALL cover a reset pulse mid-stall -> outputs 0 immediately, stall_if=0, and all registers read 0.
